// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: register map, status bit and FSM encoding shared by the i2c_wb_sequencer blocks.
package i2c_seq_pkg;
    localparam logic [31:0] REG_STATUS = 32'h00;
    localparam logic [31:0] REG_CFG    = 32'h08;
    localparam logic [31:0] REG_SADDR  = 32'h0C;
    localparam logic [31:0] REG_TXDATA = 32'h10;
    localparam logic [31:0] REG_START  = 32'h14;
    localparam int STATUS_BUSY_BIT = 0;
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ADDR, S_DATA, S_START1, S_START0, S_POLL_HI, S_POLL_LO, S_TMO
    } state_t;
endpackage

// File: rtl/i2c_seq_fifo.sv
// i2c_seq_fifo: request FIFO with full/empty flags; a push on full is taken only alongside a pop.
module i2c_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic wr, rd;
    assign empty = wptr == rptr;
    assign full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;
    assign rdata = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/i2c_wb_sequencer.sv
// i2c_wb_sequencer: queues (addr, byte) writes and plays them into i2c_master_wb over Wishbone.
// Define I2C_SEQ_TIMEOUT_EN to add the busy-poll timeout and sticky err flag.
module i2c_wb_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter logic [31:0] CFG_VALUE = 32'h0000_0000,
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_data,
    output logic        req_ready,
    output logic        busy,
    output logic        done_pulse,
    output logic        err,
    input  logic        err_clr,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    localparam logic [15:0] GAP_LOAD = POLL_GAP > 0 ? 16'(POLL_GAP - 1) : 16'd0;
    state_t state;
    logic [6:0] cur_addr, last_addr;
    logic [7:0] cur_data;
    logic last_vld;
    logic [15:0] gap;
    logic [14:0] head;
    logic full, empty, pop, push, polling;
    logic op_we;
    logic [31:0] op_adr, op_dat;
    logic unused_ok;

    assign pop = state == S_IDLE && !empty;
    assign req_ready = state != S_INIT && (!full || pop);
    assign push = req_valid && req_ready;
    assign busy = !(state == S_IDLE || state == S_INIT) || !empty;
    assign wbm_sel_o = wbm_stb_o ? 4'hF : 4'h0;
    assign polling = state == S_POLL_HI || state == S_POLL_LO;

    i2c_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(15)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .wdata({req_addr, req_data}), .rdata(head), .full(full), .empty(empty)
    );

    always_comb begin
        op_we = !polling;
        op_adr = state == S_INIT ? REG_CFG : state == S_ADDR ? REG_SADDR :
                 state == S_DATA ? REG_TXDATA : polling ? REG_STATUS : REG_START;
        op_dat = state == S_INIT ? CFG_VALUE : state == S_ADDR ? {25'b0, cur_addr} :
                 state == S_DATA ? {24'b0, cur_data} : state == S_START1 ? 32'd1 : 32'd0;
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [31:0] tcnt;
    assign unused_ok = ^wbm_dat_i[31:1];
`else
    assign err = 1'b0;
    assign unused_ok = ^{wbm_dat_i[31:1], err_clr, TIMEOUT_CYC};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            cur_addr <= '0;
            cur_data <= '0;
            last_addr <= '0;
            last_vld <= 1'b0;
            gap <= '0;
            done_pulse <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            tcnt <= '0;
            err <= 1'b0;
`endif
        end else begin
            done_pulse <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            if (err_clr) err <= 1'b0;
`endif
            if (state == S_IDLE) begin
                if (!empty) begin
                    cur_addr <= head[14:8];
                    cur_data <= head[7:0];
                    state <= (last_vld && head[14:8] == last_addr) ? S_DATA : S_ADDR;
                end
            end else if (wbm_stb_o) begin
                if (wbm_ack_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o <= 1'b0;
                    wbm_adr_o <= '0;
                    wbm_dat_o <= '0;
                    case (state)
                        S_INIT: state <= S_IDLE;
                        S_ADDR: begin
                            last_addr <= cur_addr;
                            last_vld <= 1'b1;
                            state <= S_DATA;
                        end
                        S_DATA: state <= S_START1;
                        S_START1: state <= S_START0;
                        S_START0: begin
                            state <= S_POLL_HI;
                            gap <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
                            tcnt <= '0;
`endif
                        end
                        S_POLL_HI: begin
                            gap <= GAP_LOAD;
                            if (wbm_dat_i[STATUS_BUSY_BIT]) state <= S_POLL_LO;
                        end
                        S_POLL_LO: begin
                            gap <= wbm_dat_i[STATUS_BUSY_BIT] ? GAP_LOAD : 16'd0;
                            if (!wbm_dat_i[STATUS_BUSY_BIT]) begin
                                state <= S_IDLE;
                                done_pulse <= 1'b1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (gap != 16'd0) begin
                gap <= gap - 16'd1;
            end else begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o <= op_we;
                wbm_adr_o <= op_adr;
                wbm_dat_o <= op_dat;
            end
`ifdef I2C_SEQ_TIMEOUT_EN
            // Timeout overrides any poll in flight: abort it, then clear START from S_TMO.
            if (polling) begin
                tcnt <= tcnt + 32'd1;
                if (tcnt == 32'(TIMEOUT_CYC - 1)) begin
                    err <= 1'b1;
                    last_vld <= 1'b0;
                    state <= S_TMO;
                    gap <= '0;
                    done_pulse <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o <= 1'b0;
                    wbm_adr_o <= '0;
                    wbm_dat_o <= '0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// tb_i2c_wb_sequencer: directed bench with a zero-wait i2c_master_wb register model.
module tb_i2c_wb_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid, req_ready, busy, done_pulse, err, err_clr;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0] wbm_sel_o;
    logic stuck;
    int bcnt;
    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int ndone = 0;
    int sel_bad = 0;
    int rd_bad = 0;
    logic [31:0] wadr[$];
    logic [31:0] wdat[$];

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65535;
`endif
    localparam logic [31:0] T3_ADR [11] = '{32'h0C, 32'h10, 32'h14, 32'h14, 32'h10, 32'h14,
                                             32'h14, 32'h0C, 32'h10, 32'h14, 32'h14};
    localparam logic [31:0] T3_DAT [11] = '{32'h3C, 32'h00, 32'h01, 32'h00, 32'hAF, 32'h01,
                                             32'h00, 32'h27, 32'h01, 32'h01, 32'h00};

    always #5 clk = ~clk;

    i2c_wb_sequencer #(.FIFO_DEPTH(8), .CFG_VALUE(32'h0), .POLL_GAP(4), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .busy(busy), .done_pulse(done_pulse), .err(err), .err_clr(err_clr),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
        .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    // Slave model: busy for 200 cycles after START is cleared, or forever while stuck.
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o;
    assign wbm_dat_i = {31'b0, stuck || bcnt != 0};

    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= 0;
        else if (wbm_ack_i && wbm_we_o && wbm_adr_o == 32'h14 && wbm_dat_o == 32'h0) bcnt <= 200;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always @(posedge clk) begin
        if (!rst && wbm_ack_i) begin
            if (wbm_we_o) begin
                wadr.push_back(wbm_adr_o);
                wdat.push_back(wbm_dat_o);
            end else begin
                rd_cnt++;
                if (wbm_adr_o != 32'h0) rd_bad++;
            end
            if (wbm_sel_o != 4'hF) sel_bad++;
        end
        if (!rst && done_pulse) ndone++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = a;
        req_data = d;
    endtask

    task automatic stop_drive();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic clr();
        wadr.delete();
        wdat.delete();
        rd_cnt = 0;
        ndone = 0;
    endtask

    task automatic wait_ready(input string tag, input int maxc);
        int n = 0;
        while (!req_ready && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, req_ready, 1);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_w(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_adr"}, i < wadr.size() ? wadr[i] : 32'hFFFF_FFFF, a);
        chk({tag, "_dat"}, i < wdat.size() ? wdat[i] : 32'hFFFF_FFFF, d);
    endtask

    initial begin
        int n;
        int k;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        err_clr = 1'b0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        wait_ready("cfg_ready", 20);
        chk("cfg_nwr", wadr.size(), 1);
        cmp_w("cfg", 0, 32'h08, 32'h0);

        clr();
        drive(7'h3C, 8'hAC);
        stop_drive();
        wait_idle("t2_idle", 2000);
        chk("t2_nwr", wadr.size(), 4);
        cmp_w("t2_w0", 0, 32'h0C, 32'h3C);
        cmp_w("t2_w1", 1, 32'h10, 32'hAC);
        cmp_w("t2_w2", 2, 32'h14, 32'h01);
        cmp_w("t2_w3", 3, 32'h14, 32'h00);
        chk("t2_done", ndone, 1);
        chk("t2_polled", rd_cnt >= 2, 1);

        clr();
        drive(7'h41, 8'h01);
        drive(7'h42, 8'h02);
        drive(7'h43, 8'h03);
        drive(7'h44, 8'h04);
        stop_drive();
        n = 0;
        while (!(bcnt != 0 && bcnt < 150) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rt_reach", bcnt != 0 && bcnt < 150, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbm_stb_o && n < 20);
        chk("rt_stb", wbm_stb_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("rt_cyc_drop", wbm_cyc_o, 0);
        chk("rt_stb_drop", wbm_stb_o, 0);
        chk("rt_busy", busy, 0);
        chk("rt_ready", req_ready, 0);
        repeat (3) @(negedge clk);
        clr();
        rst = 1'b0;
        wait_ready("rt_cfg_ready", 20);
        cmp_w("rt_cfg", 0, 32'h08, 32'h0);
        repeat (50) @(negedge clk);
        chk("rt_nwr", wadr.size(), 1);
        chk("rt_idle", busy, 0);
        chk("rt_ndone", ndone, 0);

        clr();
        drive(7'h3C, 8'h00);
        drive(7'h3C, 8'hAF);
        drive(7'h27, 8'h01);
        stop_drive();
        wait_idle("t3_idle", 3000);
        chk("t3_nwr", wadr.size(), 11);
        for (int i = 0; i < 11; i++) cmp_w($sformatf("t3_w%0d", i), i, T3_ADR[i], T3_DAT[i]);
        chk("t3_done", ndone, 3);

        clr();
        stuck = 1'b1;
        drive(7'h50, 8'h10);
        stop_drive();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 7; i++) drive(7'h50, 8'(8'h20 + i));
        drive(7'h50, 8'h27);
        #1 chk("pre_full_ready", req_ready, 1);
        drive(7'h55, 8'h99);
        #1 chk("full_ready", req_ready, 0);
        stop_drive();
        chk("full_hold", req_ready, 0);
        stuck = 1'b0;
        wait_idle("t4_idle", 6000);
        chk("t4_done", ndone, 9);
        chk("t4_ready", req_ready, 1);
        k = 0;
        for (int i = 0; i < wadr.size(); i++) begin
            if (wadr[i] == 32'h10) begin
                chk($sformatf("t4_tx%0d", k), wdat[i], k == 0 ? 32'h10 : 32'h1F + 32'(k));
                k++;
            end
        end
        chk("t4_ntx", k, 9);

`ifdef I2C_SEQ_TIMEOUT_EN
        clr();
        stuck = 1'b1;
        drive(7'h11, 8'h22);
        stop_drive();
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_err", err, 1);
        repeat (5) @(negedge clk);
        chk("tmo_done", ndone, 0);
        chk("tmo_idle", busy, 0);
        cmp_w("tmo_last", wadr.size() - 1, 32'h14, 32'h0);
        stuck = 1'b0;
        clr();
        drive(7'h11, 8'h33);
        stop_drive();
        wait_idle("tmo2_idle", 2000);
        cmp_w("tmo2_w0", 0, 32'h0C, 32'h11);
        chk("tmo2_done", ndone, 1);
        chk("tmo_sticky", err, 1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("tmo_clr", err, 0);
`else
        chk("err_tied", err, 0);
`endif
        chk("sel_lanes", sel_bad, 0);
        chk("read_addr", rd_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
